// File: rtl/alu_pkg.sv
// Shared opcode constants, datapath width and buffer state type for the shared Execute ALU.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 64;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_t;

endpackage

// File: rtl/alu_core_64.sv
// Combinational add/sub/and/xor datapath with Y86 zero, sign and overflow flags.
module alu_core_64
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (op)
            ALU_ADD: begin
                result = a + b;
                of     = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                result = a - b;
                of     = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result = a & b;
            ALU_XOR: result = a ^ b;
            default: result = '0;
        endcase
        zf = (result == '0);
        sf = result[WIDTH-1];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for the shared ALU, with a one-entry
// registered response buffer and the architectural condition-code register.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req0_setcc,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic             req1_setcc,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zf,
    output logic             resp_sf,
    output logic             resp_of,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of
);

    buf_state_t       state, state_next;
    logic             can_accept;
    logic             last_grant;
    logic             grant0, grant1, accept;
    logic [1:0]       op_sel;
    logic [WIDTH-1:0] a_sel, b_sel;
    logic             setcc_sel;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zf, alu_sf, alu_of;

    // Buffer FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state <= BUF_EMPTY;
        else     state <= state_next;
    end

    // Buffer FSM: next state (a same-cycle accept keeps it FULL for back-to-back ops)
    always_comb begin
        state_next = state;
        case (state)
            BUF_EMPTY: if (accept) state_next = BUF_FULL;
            BUF_FULL:  if (resp_ready && !accept) state_next = BUF_EMPTY;
            default:   state_next = BUF_EMPTY;
        endcase
    end

    // Buffer FSM: outputs
    always_comb begin
        resp_valid = (state == BUF_FULL);
        can_accept = !resp_valid || resp_ready;
    end

    // On contention the requester that did not win last time is favoured
    always_comb begin
        grant0 = can_accept && req0_valid && (!req1_valid || last_grant);
        grant1 = can_accept && req1_valid && (!req0_valid || !last_grant);
        accept = grant0 || grant1;
        req0_ready = grant0;
        req1_ready = grant1;
    end

    always_comb begin
        op_sel    = grant1 ? req1_op    : req0_op;
        a_sel     = grant1 ? req1_a     : req0_a;
        b_sel     = grant1 ? req1_b     : req0_b;
        setcc_sel = grant1 ? req1_setcc : req0_setcc;
    end

    alu_core_64 #(.WIDTH(WIDTH)) u_core (
        .op     (op_sel),
        .a      (a_sel),
        .b      (b_sel),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_id     <= 1'b0;
            resp_result <= '0;
            resp_zf     <= 1'b0;
            resp_sf     <= 1'b0;
            resp_of     <= 1'b0;
            cc_zf       <= 1'b1;
            cc_sf       <= 1'b0;
            cc_of       <= 1'b0;
            last_grant  <= 1'b1;
        end else if (accept) begin
            resp_id     <= grant1;
            resp_result <= alu_result;
            resp_zf     <= alu_zf;
            resp_sf     <= alu_sf;
            resp_of     <= alu_of;
            last_grant  <= grant1;
            if (setcc_sel) begin
                cc_zf <= alu_zf;
                cc_sf <= alu_sf;
                cc_of <= alu_of;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scenarios plus constrained-random traffic checked every cycle against a behavioural model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_setcc;
    logic [1:0]  req0_op;
    logic [63:0] req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_setcc;
    logic [1:0]  req1_op;
    logic [63:0] req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id;
    logic [63:0] resp_result;
    logic        resp_zf, resp_sf, resp_of;
    logic        cc_zf, cc_sf, cc_of;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic        m_valid, m_id, m_last;
    logic [63:0] m_result;
    logic        m_zf, m_sf, m_of;
    logic        m_cc_zf, m_cc_sf, m_cc_of;
    logic        exp_g0, exp_g1;

    always #5 clk = ~clk;

    alu_share_arbiter #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b), .req0_setcc(req0_setcc),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b), .req1_setcc(req1_setcc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_result(resp_result), .resp_zf(resp_zf), .resp_sf(resp_sf), .resp_of(resp_of),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Signed overflow taken from a 65-bit signed sum/difference that does not fit in 64 bits
    function automatic void alu_ref(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                                    output logic [63:0] r, output logic z, output logic s, output logic o);
        logic signed [64:0] wide;
        o = 1'b0;
        case (op)
            2'd0: begin wide = $signed({a[63], a}) + $signed({b[63], b}); r = wide[63:0]; o = wide[64] ^ wide[63]; end
            2'd1: begin wide = $signed({a[63], a}) - $signed({b[63], b}); r = wide[63:0]; o = wide[64] ^ wide[63]; end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        z = (r == 64'd0);
        s = r[63];
    endfunction

    // One clock: compare just before the edge, then advance the model with the sampled inputs
    task automatic step();
        logic can, pick, take;
        logic [63:0] r;
        logic z, s, o;
        #1;
        can = !m_valid || resp_ready;
        take = 1'b0;
        pick = 1'b0;
        if (can) begin
            if (req0_valid && req1_valid) begin take = 1'b1; pick = ~m_last; end
            else if (req0_valid)          begin take = 1'b1; pick = 1'b0; end
            else if (req1_valid)          begin take = 1'b1; pick = 1'b1; end
        end
        exp_g0 = take && !pick;
        exp_g1 = take && pick;
        if (!rst) begin
            check("req0_ready", req0_ready, exp_g0);
            check("req1_ready", req1_ready, exp_g1);
            check("resp_valid", resp_valid, m_valid);
            check("resp_id", resp_id, m_id);
            check("resp_result", resp_result, m_result);
            check("resp_flags", {resp_zf, resp_sf, resp_of}, {m_zf, m_sf, m_of});
            check("cc", {cc_zf, cc_sf, cc_of}, {m_cc_zf, m_cc_sf, m_cc_of});
        end
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_id = 1'b0; m_result = '0;
            {m_zf, m_sf, m_of} = 3'b000;
            {m_cc_zf, m_cc_sf, m_cc_of} = 3'b100;
            m_last = 1'b1;
        end else if (take) begin
            if (pick) alu_ref(req1_op, req1_a, req1_b, r, z, s, o);
            else      alu_ref(req0_op, req0_a, req0_b, r, z, s, o);
            m_valid = 1'b1; m_id = pick; m_last = pick;
            m_result = r; {m_zf, m_sf, m_of} = {z, s, o};
            if (pick ? req1_setcc : req0_setcc) {m_cc_zf, m_cc_sf, m_cc_of} = {z, s, o};
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int n, input logic v, input logic [1:0] op,
                           input logic [63:0] a, input logic [63:0] b, input logic sc);
        if (n == 0) begin req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_setcc = sc; end
        else        begin req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_setcc = sc; end
    endtask

    function automatic logic [63:0] rand_operand();
        logic [63:0] corner [5];
        corner[0] = 64'd0;
        corner[1] = 64'd1;
        corner[2] = '1;
        corner[3] = 64'h8000_0000_0000_0000;
        corner[4] = 64'h7FFF_FFFF_FFFF_FFFF;
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        rst = 1'b1;
        resp_ready = 1'b1;
        set_req(0, 1'b0, 2'd0, '0, '0, 1'b0);
        set_req(1, 1'b0, 2'd0, '0, '0, 1'b0);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_result", resp_result, 64'd0);
        check("rst_cc", {cc_zf, cc_sf, cc_of}, 3'b100);

        // Contention from reset alternates 0,1,0,1 with one response per cycle
        for (int i = 0; i < 4; i++) begin
            set_req(0, 1'b1, 2'd0, 64'(i), 64'd1, 1'b0);
            set_req(1, 1'b1, 2'd3, 64'(i), 64'd5, 1'b0);
            #1;
            check("rr_ready0", req0_ready, (i % 2) == 0);
            step();
            check("rr_resp_valid", resp_valid, 1'b1);
            check("rr_resp_id", resp_id, (i % 2) != 0);
        end

        // req0 SUB 9-10 with setcc
        set_req(0, 1'b1, 2'd1, 64'd9, 64'd10, 1'b1);
        set_req(1, 1'b0, 2'd0, '0, '0, 1'b0);
        step();
        check("sub_id", resp_id, 1'b0);
        check("sub_result", resp_result, 64'hFFFF_FFFF_FFFF_FFFF);
        check("sub_flags", {resp_zf, resp_sf, resp_of}, 3'b010);
        check("sub_cc", {cc_zf, cc_sf, cc_of}, 3'b010);

        // Signed overflow corners from req1
        set_req(0, 1'b0, 2'd0, '0, '0, 1'b0);
        set_req(1, 1'b1, 2'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        step();
        check("addov_result", resp_result, 64'h8000_0000_0000_0000);
        check("addov_flags", {resp_zf, resp_sf, resp_of}, 3'b011);
        set_req(1, 1'b1, 2'd1, 64'h8000_0000_0000_0000, 64'd1, 1'b1);
        step();
        check("subov_result", resp_result, 64'h7FFF_FFFF_FFFF_FFFF);
        check("subov_flags", {resp_zf, resp_sf, resp_of}, 3'b001);

        // Held response: no ready, stable payload; release accepts the pending request
        resp_ready = 1'b0;
        set_req(0, 1'b1, 2'd3, 64'hAA, 64'h55, 1'b0);
        set_req(1, 1'b1, 2'd3, 64'h11, 64'h22, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("hold_ready", {req0_ready, req1_ready}, 2'b00);
            step();
            check("hold_result", resp_result, 64'h7FFF_FFFF_FFFF_FFFF);
            check("hold_valid", resp_valid, 1'b1);
        end
        resp_ready = 1'b1;
        #1;
        check("release_ready0", req0_ready, 1'b1);
        step();
        check("release_result", resp_result, 64'hFF);

        // AND to zero without setcc leaves cc alone
        set_req(0, 1'b1, 2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0);
        set_req(1, 1'b0, 2'd0, '0, '0, 1'b0);
        step();
        check("and_result", resp_result, 64'd0);
        check("and_zf", resp_zf, 1'b1);
        check("and_cc", {cc_zf, cc_sf, cc_of}, 3'b001);

        // Reset with a full buffer
        rst = 1'b1;
        set_req(0, 1'b1, 2'd0, 64'd3, 64'd4, 1'b1);
        set_req(1, 1'b1, 2'd0, 64'd5, 64'd6, 1'b1);
        step();
        rst = 1'b0;
        #1;
        check("rst2_valid", resp_valid, 1'b0);
        check("rst2_cc", {cc_zf, cc_sf, cc_of}, 3'b100);
        check("rst2_ready0", req0_ready, 1'b1);
        step();

        // Random traffic; payload held while a request is waiting
        for (int i = 0; i < 1500; i++) begin
            logic hold0, hold1;
            hold0 = req0_valid && !exp_g0 && !rst;
            hold1 = req1_valid && !exp_g1 && !rst;
            rst = ($urandom_range(0, 99) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            if (!hold0) set_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            if (!hold1) set_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                                rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
